// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl
// SPI mode-0 master for the SPI slave register-access frame. A frame has three
// WIDTH-bit words sent MSB first: command, address, data. One Start pulse makes
// one full SS/SCLK/MOSI frame. On a read frame, the last WIDTH bits captured
// from MISO are returned on Rd_Data.
//
// Optional feature (macro SPI_MASTER_BURST_EN): adds Burst_Next/Burst_Data.
// These extend a frame with more data words while SS stays low.
//
// Ports:
//   CLK        system clock, rising edge
//   RST        asynchronous active-low reset
//   Start      request pulse, accepted only while Busy=0
//   Op_Rd      1=read frame, 0=write frame (sampled with Start)
//   Address    register address (sampled with Start)
//   Wr_Data    write data (sampled with Start)
//   MISO       serial data from the slave
//   SCLK       serial clock, idle low
//   SS         slave select, active low
//   MOSI       serial data to the slave
//   Busy       frame in progress
//   Done       one-cycle pulse at the end of each data word
//   Rd_Data    last read data word
//   Burst_Next (burst build) continue with another data word
//   Burst_Data (burst build) next write data word
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | SS high, waiting for Start
// SETUP    | SS low, SCLK low for CLK_DIV cycles before the first edge
// SHIFT_HI | SCLK high; MISO sampled on the first cycle
// SHIFT_LO | SCLK low; MOSI already advanced; end of frame decided here
module spi_master_ctrl #(
    parameter int WIDTH   = 8,
    parameter int CLK_DIV = 2,
    parameter int WR_CMD  = 1,
    parameter int RD_CMD  = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Start,
    input  logic             Op_Rd,
    input  logic [WIDTH-1:0] Address,
    input  logic [WIDTH-1:0] Wr_Data,
    input  logic             MISO,
`ifdef SPI_MASTER_BURST_EN
    input  logic             Burst_Next,
    input  logic [WIDTH-1:0] Burst_Data,
`endif
    output logic             SCLK,
    output logic             SS,
    output logic             MOSI,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Rd_Data
);

    localparam int FRAME = 3 * WIDTH;
    localparam int BCW   = $clog2(FRAME + 1);
    localparam int DW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0]  DIV_LOAD   = DW'(CLK_DIV - 1);
    localparam logic [BCW-1:0] BIT_LAST   = BCW'(FRAME);
    localparam logic [BCW-1:0] BIT_BURST  = BCW'(2 * WIDTH);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SETUP    = 2'd1,
        SHIFT_HI = 2'd2,
        SHIFT_LO = 2'd3
    } state_t;

    state_t             state;
    logic [FRAME-1:0]   shift_reg;
    logic [WIDTH-1:0]   rx_reg;
    logic [DW-1:0]      div_cnt;
    logic [BCW-1:0]     bit_cnt;
    logic               op_rd;

    logic [WIDTH-1:0]   cmd_word;
    logic [WIDTH-1:0]   data_word;
    logic               burst_go;
    logic [WIDTH-1:0]   burst_word;

    assign cmd_word  = Op_Rd ? WIDTH'(RD_CMD) : WIDTH'(WR_CMD);
    assign data_word = Op_Rd ? '0 : Wr_Data;

`ifdef SPI_MASTER_BURST_EN
    assign burst_go   = Burst_Next;
    assign burst_word = op_rd ? '0 : Burst_Data;
`else
    assign burst_go   = 1'b0;
    assign burst_word = '0;
`endif

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= IDLE;
            shift_reg <= '0;
            rx_reg    <= '0;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            op_rd     <= 1'b0;
            SCLK      <= 1'b0;
            SS        <= 1'b1;
            MOSI      <= 1'b0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
            Rd_Data   <= '0;
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start) begin
                        op_rd     <= Op_Rd;
                        shift_reg <= {cmd_word, Address, data_word};
                        MOSI      <= cmd_word[WIDTH-1];
                        SS        <= 1'b0;
                        Busy      <= 1'b1;
                        div_cnt   <= DIV_LOAD;
                        bit_cnt   <= '0;
                        state     <= SETUP;
                    end
                end

                SETUP: begin
                    if (div_cnt == '0) begin
                        SCLK    <= 1'b1;
                        div_cnt <= DIV_LOAD;
                        state   <= SHIFT_HI;
                    end else begin
                        div_cnt <= div_cnt - 1'b1;
                    end
                end

                SHIFT_HI: begin
                    // The first cycle of the high phase is the cycle after SCLK rose.
                    // A mode-0 slave has held MISO stable since the previous fall.
                    if (div_cnt == DIV_LOAD) begin
                        rx_reg  <= {rx_reg[WIDTH-2:0], MISO};
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                    if (div_cnt == '0) begin
                        SCLK      <= 1'b0;
                        div_cnt   <= DIV_LOAD;
                        // Zeros shift in from the bottom, so MOSI drops to 0 after the last bit.
                        shift_reg <= shift_reg << 1;
                        MOSI      <= shift_reg[FRAME-2];
                        state     <= SHIFT_LO;
                    end else begin
                        div_cnt <= div_cnt - 1'b1;
                    end
                end

                SHIFT_LO: begin
                    if (div_cnt != '0) begin
                        div_cnt <= div_cnt - 1'b1;
                    end else if (bit_cnt == BIT_LAST) begin
                        Done <= 1'b1;
                        if (op_rd) begin
                            Rd_Data <= rx_reg;
                        end
                        if (burst_go) begin
                            // Rewind the bit count so that exactly one more data word follows.
                            shift_reg <= {burst_word, {(2 * WIDTH){1'b0}}};
                            MOSI      <= burst_word[WIDTH-1];
                            bit_cnt   <= BIT_BURST;
                            SCLK      <= 1'b1;
                            div_cnt   <= DIV_LOAD;
                            state     <= SHIFT_HI;
                        end else begin
                            SS    <= 1'b1;
                            Busy  <= 1'b0;
                            MOSI  <= 1'b0;
                            state <= IDLE;
                        end
                    end else begin
                        SCLK    <= 1'b1;
                        div_cnt <= DIV_LOAD;
                        state   <= SHIFT_HI;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed testbench for spi_master_ctrl (WIDTH=8, CLK_DIV=2).
// The bench has a small mode-0 slave. It records MOSI on each SCLK rise and drives
// MISO from miso_frame after SS falls and after each SCLK fall.
module tb_spi_master_ctrl;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       Start = 1'b0;
    logic       Op_Rd = 1'b0;
    logic [7:0] Address = 8'h00;
    logic [7:0] Wr_Data = 8'h00;
    logic       MISO = 1'b0;
    logic       SCLK, SS, MOSI, Busy, Done;
    logic [7:0] Rd_Data;
`ifdef SPI_MASTER_BURST_EN
    logic       Burst_Next = 1'b0;
    logic [7:0] Burst_Data = 8'h00;
`endif

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] mosi_cap = '0;
    int          sclk_cnt = 0;
    int          ss_low = 0;
    int          done_cnt = 0;
    int          fall_idx = 0;
    logic [23:0] miso_frame = '0;

    spi_master_ctrl #(.WIDTH(8), .CLK_DIV(2), .WR_CMD(1), .RD_CMD(2)) dut (
        .CLK     (CLK),
        .RST     (RST),
        .Start   (Start),
        .Op_Rd   (Op_Rd),
        .Address (Address),
        .Wr_Data (Wr_Data),
        .MISO    (MISO),
`ifdef SPI_MASTER_BURST_EN
        .Burst_Next (Burst_Next),
        .Burst_Data (Burst_Data),
`endif
        .SCLK    (SCLK),
        .SS      (SS),
        .MOSI    (MOSI),
        .Busy    (Busy),
        .Done    (Done),
        .Rd_Data (Rd_Data)
    );

    always #5 CLK = ~CLK;

    always @(posedge SCLK) begin
        mosi_cap = {mosi_cap[30:0], MOSI};
        sclk_cnt++;
    end

    always @(negedge SS) begin
        fall_idx = 0;
        MISO = miso_frame[23];
    end

    always @(negedge SCLK) begin
        if (!SS) begin
            fall_idx++;
            MISO = (fall_idx < 24) ? miso_frame[23 - fall_idx] : 1'b0;
        end
    end

    always @(negedge CLK) begin
        if (!SS) ss_low++;
        if (Done) done_cnt++;
    end

    task clear_mon();
        mosi_cap = '0;
        sclk_cnt = 0;
        ss_low   = 0;
        done_cnt = 0;
    endtask

    // The inputs are scrambled right after acceptance. A frame that still reads them shows up wrong.
    task start_frame(input logic rd, input logic [7:0] a, input logic [7:0] d);
        @(negedge CLK);
        clear_mon();
        Op_Rd = rd; Address = a; Wr_Data = d; Start = 1'b1;
        @(negedge CLK);
        Start = 1'b0; Op_Rd = ~rd; Address = ~a; Wr_Data = ~d;
    endtask

    task wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (Done === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge CLK);
        end
    endtask

    task test_reset();
        repeat (3) @(negedge CLK);
        vectors++;
        if ({SS, SCLK, MOSI, Busy, Done, Rd_Data} !== {5'b10000, 8'h00}) begin
            miscompares++;
            $display("FAIL reset_held: got SS,SCLK,MOSI,Busy,Done,Rd_Data=%b expected %b",
                     {SS, SCLK, MOSI, Busy, Done, Rd_Data}, {5'b10000, 8'h00});
        end
        RST = 1'b1;
        repeat (4) @(negedge CLK);
        vectors++;
        if ({SS, SCLK, MOSI, Busy, Done, Rd_Data} !== {5'b10000, 8'h00}) begin
            miscompares++;
            $display("FAIL reset_idle: got SS,SCLK,MOSI,Busy,Done,Rd_Data=%b expected %b",
                     {SS, SCLK, MOSI, Busy, Done, Rd_Data}, {5'b10000, 8'h00});
        end
    endtask

    task test_write();
        bit ok;
        miso_frame = 24'hFFFFFF;
        start_frame(1'b0, 8'h3C, 8'h5A);
        wait_done(ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL write_done_timeout: got no Done expected Done within 400 cycles");
            return;
        end
        vectors++;
        if ({SS, Busy, MOSI, Rd_Data} !== {3'b100, 8'h00}) begin
            miscompares++;
            $display("FAIL write_end: got SS,Busy,MOSI,Rd_Data=%b expected %b",
                     {SS, Busy, MOSI, Rd_Data}, {3'b100, 8'h00});
        end
        @(negedge CLK);
        vectors++;
        if (Done !== 1'b0) begin
            miscompares++;
            $display("FAIL write_done_width: got Done=%b expected 0", Done);
        end
        repeat (5) @(negedge CLK);
        vectors++;
        if (mosi_cap[23:0] !== 24'h013C5A) begin
            miscompares++;
            $display("FAIL write_mosi: got %h expected 013c5a", mosi_cap[23:0]);
        end
        vectors++;
        if (sclk_cnt !== 24) begin
            miscompares++;
            $display("FAIL write_sclk_pulses: got %0d expected 24", sclk_cnt);
        end
        vectors++;
        if (ss_low !== 98) begin
            miscompares++;
            $display("FAIL write_ss_low: got %0d expected 98", ss_low);
        end
        vectors++;
        if (done_cnt !== 1) begin
            miscompares++;
            $display("FAIL write_done_count: got %0d expected 1", done_cnt);
        end
    endtask

    task test_read();
        bit ok;
        miso_frame = 24'hA55AC3;
        start_frame(1'b1, 8'h10, 8'h77);
        wait_done(ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL read_done_timeout: got no Done expected Done within 400 cycles");
            return;
        end
        vectors++;
        if (Rd_Data !== 8'hC3) begin
            miscompares++;
            $display("FAIL read_data: got %h expected c3", Rd_Data);
        end
        repeat (3) @(negedge CLK);
        vectors++;
        if (mosi_cap[23:0] !== 24'h021000 || sclk_cnt !== 24) begin
            miscompares++;
            $display("FAIL read_mosi: got %h/%0d pulses expected 021000/24", mosi_cap[23:0], sclk_cnt);
        end
    endtask

    task test_ignore_start();
        bit ok;
        miso_frame = 24'hFFFF96;
        start_frame(1'b1, 8'h44, 8'h00);
        repeat (30) @(negedge CLK);
        vectors++;
        if (Busy !== 1'b1) begin
            miscompares++;
            $display("FAIL ignore_busy: got Busy=%b expected 1", Busy);
        end
        Op_Rd = 1'b0; Address = 8'hFF; Wr_Data = 8'hEE; Start = 1'b1;
        @(negedge CLK);
        Start = 1'b0;
        wait_done(ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL ignore_done_timeout: got no Done expected Done within 400 cycles");
            return;
        end
        vectors++;
        if (Rd_Data !== 8'h96) begin
            miscompares++;
            $display("FAIL ignore_rd_data: got %h expected 96", Rd_Data);
        end
        repeat (10) @(negedge CLK);
        vectors++;
        if (mosi_cap[23:0] !== 24'h024400 || done_cnt !== 1 || ss_low !== 98) begin
            miscompares++;
            $display("FAIL ignore_frame: got mosi=%h done=%0d ss_low=%0d expected 024400/1/98",
                     mosi_cap[23:0], done_cnt, ss_low);
        end
    endtask

    task test_back_to_back();
        bit ok;
        start_frame(1'b0, 8'h01, 8'h02);
        wait_done(ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL b2b_first_timeout: got no Done expected Done within 400 cycles");
            return;
        end
        Op_Rd = 1'b0; Address = 8'h55; Wr_Data = 8'hAA; Start = 1'b1;
        mosi_cap = '0; sclk_cnt = 0;
        @(negedge CLK);
        Start = 1'b0; Address = 8'h00; Wr_Data = 8'h00;
        vectors++;
        if ({Busy, SS} !== 2'b10) begin
            miscompares++;
            $display("FAIL b2b_accept: got Busy,SS=%b expected 10", {Busy, SS});
        end
        wait_done(ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL b2b_second_timeout: got no Done expected Done within 400 cycles");
            return;
        end
        repeat (3) @(negedge CLK);
        vectors++;
        if (mosi_cap[23:0] !== 24'h0155AA || sclk_cnt !== 24) begin
            miscompares++;
            $display("FAIL b2b_mosi: got %h/%0d pulses expected 0155aa/24", mosi_cap[23:0], sclk_cnt);
        end
    endtask

    task test_reset_mid_frame();
        bit ok;
        bit hit;
        miso_frame = 24'h000000;
        start_frame(1'b0, 8'h3C, 8'h5A);
        hit = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (sclk_cnt == 11) begin
                hit = 1'b1;
                break;
            end
            @(negedge CLK);
        end
        vectors++;
        if (!hit) begin
            miscompares++;
            $display("FAIL rst_mid_reach_bit11: got %0d pulses expected 11", sclk_cnt);
            return;
        end
        RST = 1'b0;
        #1;
        vectors++;
        if ({SS, SCLK, Busy, MOSI, Done, Rd_Data} !== {5'b10000, 8'h00}) begin
            miscompares++;
            $display("FAIL rst_mid_outputs: got SS,SCLK,Busy,MOSI,Done,Rd_Data=%b expected %b",
                     {SS, SCLK, Busy, MOSI, Done, Rd_Data}, {5'b10000, 8'h00});
        end
        @(negedge CLK);
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        start_frame(1'b0, 8'h7E, 8'h81);
        wait_done(ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL rst_mid_done_timeout: got no Done expected Done within 400 cycles");
            return;
        end
        repeat (3) @(negedge CLK);
        vectors++;
        if (mosi_cap[23:0] !== 24'h017E81 || sclk_cnt !== 24 || ss_low !== 98) begin
            miscompares++;
            $display("FAIL rst_mid_clean_frame: got mosi=%h pulses=%0d ss_low=%0d expected 017e81/24/98",
                     mosi_cap[23:0], sclk_cnt, ss_low);
        end
    endtask

`ifdef SPI_MASTER_BURST_EN
    task test_burst();
        bit ok;
        Burst_Next = 1'b1; Burst_Data = 8'h22;
        start_frame(1'b0, 8'h20, 8'h11);
        wait_done(ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL burst_first_timeout: got no Done expected Done within 400 cycles");
            return;
        end
        Burst_Next = 1'b0;
        vectors++;
        if ({SS, Busy} !== 2'b01) begin
            miscompares++;
            $display("FAIL burst_ss_held: got SS,Busy=%b expected 01", {SS, Busy});
        end
        @(negedge CLK);
        wait_done(ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL burst_second_timeout: got no Done expected Done within 400 cycles");
            return;
        end
        repeat (3) @(negedge CLK);
        vectors++;
        if (mosi_cap !== 32'h01201122 || sclk_cnt !== 32 || done_cnt !== 2 || SS !== 1'b1) begin
            miscompares++;
            $display("FAIL burst_frame: got mosi=%h pulses=%0d done=%0d SS=%b expected 01201122/32/2/1",
                     mosi_cap, sclk_cnt, done_cnt, SS);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_write();
        test_read();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid_frame();
`ifdef SPI_MASTER_BURST_EN
        test_burst();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
